// File: rtl/mips_pkg.sv
// Shared encodings for the 5-bit-address MIPS pipeline: opcodes, R-type
// function codes, ALU operation codes and the ID/EX control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // How the 16-bit immediate field is widened for execute
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,
    IMM_SIGN = 2'd1,
    IMM_ZERO = 2'd2
  } imm_kind_e;

  // Control bits carried from ID into EX
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
  } idex_ctrl_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through
// bypass, one synchronous write port, r0 hardwired to zero.
module register_file #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic [$clog2(NREG)-1:0]  rs_addr_i,
  input  logic [$clog2(NREG)-1:0]  rt_addr_i,
  input  logic                     we_i,
  input  logic [$clog2(NREG)-1:0]  waddr_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rs_data_o,
  output logic [DW-1:0]            rt_data_o
);

  localparam int RA = $clog2(NREG);

  logic [DW-1:0] regs_q [NREG];
  logic          rs_byp, rt_byp;

  // Storage: cleared on reset, written on the clock edge except for r0
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A write landing this cycle is forwarded so ID sees the newest value
  assign rs_byp = we_i && (waddr_i == rs_addr_i);
  assign rt_byp = we_i && (waddr_i == rt_addr_i);

  assign rs_data_o = (rs_addr_i == RA'(0)) ? '0 :
                     rs_byp ? wdata_i : regs_q[rs_addr_i];
  assign rt_data_o = (rt_addr_i == RA'(0)) ? '0 :
                     rt_byp ? wdata_i : regs_q[rt_addr_i];

endmodule

// File: rtl/instruction_decode.sv
// ID stage: register read, field/control decode, J/JR resolution back to
// fetch, load-use stall detection and the ID/EX pipeline register.
module instruction_decode #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             instruction,
  input  logic [AW-1:0]           pc_4,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [DW-1:0]           wb_data,
  output logic                    mux_ctrl,
  output logic [AW-1:0]           jp_address,
  output logic                    stall,
  output logic                    ex_valid,
  output logic [DW-1:0]           ex_rs_data,
  output logic [DW-1:0]           ex_rt_data,
  output logic [DW-1:0]           ex_imm,
  output logic [$clog2(NREG)-1:0] ex_dest,
  output logic [2:0]              ex_alu_op,
  output logic                    ex_alu_src,
  output logic                    ex_reg_write,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write,
  output logic                    ex_mem_to_reg,
  output logic [AW-1:0]           ex_pc_4,
  output logic                    illegal
);

  import mips_pkg::*;

  localparam int RA = $clog2(NREG);

  function automatic logic [DW-1:0] ext_imm(input logic [15:0] imm, input imm_kind_e kind);
    case (kind)
      IMM_SIGN: ext_imm = {{(DW-16){imm[15]}}, imm};
      IMM_ZERO: ext_imm = {{(DW-16){1'b0}}, imm};
      default:  ext_imm = '0;
    endcase
  endfunction

  logic [5:0]    opcode, funct;
  logic [RA-1:0] rs_a, rt_a, rd_a;
  logic [DW-1:0] rs_data, rt_data;

  idex_ctrl_t    ctrl_dec;
  logic [RA-1:0] dest_dec;
  imm_kind_e     imm_kind;
  logic          reads_rt, is_j, is_jr, ill_dec, carries_ops;
  logic          hazard, issue;

  logic          kill_d, kill_q;
  logic          ex_valid_d, ex_valid_q;
  logic [DW-1:0] rs_d, rs_q, rt_d, rt_q, imm_d, imm_q;
  logic [RA-1:0] dest_d, dest_q;
  idex_ctrl_t    ctrl_d, ctrl_q;
  logic [AW-1:0] pc_d, pc_q;
  logic          illegal_d, illegal_q;

  assign opcode = instruction[31:26];
  assign rs_a   = instruction[25:21];
  assign rt_a   = instruction[20:16];
  assign rd_a   = instruction[15:11];
  assign funct  = instruction[5:0];

  register_file #(.NREG(NREG), .DW(DW)) u_rf (
    .clk       (clk),
    .rst_ni    (reset),
    .rs_addr_i (rs_a),
    .rt_addr_i (rt_a),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data)
  );

  // Decode opcode/funct into EX control, destination, immediate form and jump type
  always_comb begin
    ctrl_dec    = '0;
    dest_dec    = '0;
    imm_kind    = IMM_NONE;
    reads_rt    = 1'b0;
    is_j        = 1'b0;
    is_jr       = 1'b0;
    ill_dec     = 1'b0;
    carries_ops = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (instruction != 32'h0) begin
          case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
              carries_ops        = 1'b1;
              reads_rt           = 1'b1;
              dest_dec           = rd_a;
              ctrl_dec.reg_write = 1'b1;
              case (funct)
                F_SUB:   ctrl_dec.alu_op = ALU_SUB;
                F_AND:   ctrl_dec.alu_op = ALU_AND;
                F_OR:    ctrl_dec.alu_op = ALU_OR;
                F_SLT:   ctrl_dec.alu_op = ALU_SLT;
                default: ctrl_dec.alu_op = ALU_ADD;
              endcase
            end
            F_JR:    is_jr   = 1'b1;
            default: ill_dec = 1'b1;
          endcase
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        carries_ops        = 1'b1;
        dest_dec           = rt_a;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        imm_kind           = (opcode == OP_ADDI) ? IMM_SIGN : IMM_ZERO;
        ctrl_dec.alu_op    = (opcode == OP_ADDI) ? ALU_ADD :
                             (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
      end
      OP_LW: begin
        carries_ops         = 1'b1;
        dest_dec            = rt_a;
        imm_kind            = IMM_SIGN;
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        carries_ops        = 1'b1;
        reads_rt           = 1'b1;
        dest_dec           = rt_a;
        imm_kind           = IMM_SIGN;
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
      end
      OP_J:    is_j    = 1'b1;
      default: ill_dec = 1'b1;
    endcase
  end

  // Load-use hazard against the load now in EX; a killed slot never stalls
  assign hazard = ex_valid_q && ctrl_q.mem_read && (dest_q != '0) &&
                  ((dest_q == rs_a) || ((dest_q == rt_a) && reads_rt));
  assign stall  = !kill_q && hazard;
  assign issue  = !kill_q && !stall;

  assign mux_ctrl   = issue && (is_j || is_jr);
  assign jp_address = is_jr ? rs_data[AW-1:0] : instruction[AW-1:0];
  assign kill_d     = mux_ctrl;

  // Next ID/EX contents: empty bubble on kill/stall, decoded word otherwise
  always_comb begin
    ex_valid_d = 1'b0;
    rs_d       = '0;
    rt_d       = '0;
    imm_d      = '0;
    dest_d     = '0;
    ctrl_d     = '0;
    pc_d       = '0;
    illegal_d  = 1'b0;
    if (issue) begin
      ex_valid_d = 1'b1;
      pc_d       = pc_4;
      illegal_d  = ill_dec;
      if (carries_ops) begin
        rs_d   = rs_data;
        rt_d   = rt_data;
        imm_d  = ext_imm(instruction[15:0], imm_kind);
        dest_d = dest_dec;
        ctrl_d = ctrl_dec;
      end
    end
  end

  // ---- ID / EX boundary ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kill_q     <= 1'b0;
      ex_valid_q <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      dest_q     <= '0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      illegal_q  <= 1'b0;
    end else begin
      kill_q     <= kill_d;
      ex_valid_q <= ex_valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      imm_q      <= imm_d;
      dest_q     <= dest_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      illegal_q  <= illegal_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_rs_data    = rs_q;
  assign ex_rt_data    = rt_q;
  assign ex_imm        = imm_q;
  assign ex_dest       = dest_q;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_pc_4       = pc_q;
  assign illegal       = illegal_q;

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- ID stage of the 5-bit-address MIPS pipeline. Sits directly downstream of instruction fetch and consumes its 32-bit instruction and its PC_4.
- Holds the 32x32 register file, decodes fields and control, and detects load-use hazards.
- Registers the ID/EX bundle for execute.
- Resolves J/JR in ID and returns mux_ctrl/jp_address to fetch combinationally.

Parameters:
- NREG, 32, register count (addresses 5 bits; r0 hardwired to zero)
- DW, 32, datapath width
- AW, 5, instruction address width (matches fetch PC)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- instruction  in  32  word from fetch, valid in the current cycle
- pc_4  in  5  PC_4 from fetch, paired with instruction
- wb_en  in  1  write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  32  write-back data
- mux_ctrl  out  1  combinational; 1 = fetch takes jp_address
- jp_address  out  5  combinational jump target
- stall  out  1  combinational load-use stall; PC and fetch hold
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs_data, ex_rt_data  out  32 each  operand values
- ex_imm  out  32  sign-extended imm (addi/lw/sw); zero-extended (andi/ori)
- ex_dest  out  5  rd for R-type, rt for I-type
- ex_alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT
- ex_alu_src  out  1  1 = use ex_imm
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each
- ex_pc_4  out  5  passed through
- illegal  out  1  registered; unknown opcode/funct seen

Behaviour:
- Reset (low, asynchronous):
  - All ex_* outputs and illegal are 0; ex_valid = 0.
  - Register file cleared to 0; kill flag cleared.
- Decoded set:
  - R-type op 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x08 jr.
  - addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, j 0x02.
  - Word 0x00000000 is a NOP: ex_valid = 1, all control bits 0.
  - Any other opcode/funct: all control bits 0 and illegal = 1 for that cycle; ex_valid still 1.
- Register file:
  - Two combinational read ports (rs, rt) and one synchronous write port.
  - Writes to r0 are ignored.
  - Same-cycle write/read bypass: when wb_en is high and wb_addr equals rs or rt (and is not 0), the read returns wb_data.
- Latency: one cycle. The ID/EX bundle updates on the rising edge after the instruction is presented.
- Jumps:
  - J: mux_ctrl = 1, jp_address = instruction[4:0].
  - JR: mux_ctrl = 1, jp_address = bypassed rs_data[4:0].
  - Jumps write no register and enter EX as a bubble (ex_valid = 1, controls 0).
  - Kill: the instruction arriving in the next cycle (the wrong-path word already fetched) is replaced by a bubble with ex_valid = 0.
- Load-use hazard:
  - Condition: ex_valid && ex_mem_read && ex_dest != 0 && (ex_dest == rs || (ex_dest == rt && the instruction reads rt)).
  - Response: stall = 1 and ID/EX is loaded with a bubble (ex_valid = 0).
  - The same instruction is re-decoded next cycle; fetch must hold its word.
  - mux_ctrl is suppressed (0) while stall = 1, so a JR behind a load waits.
- Priority: reset > kill > stall > normal decode. A killed slot never raises stall.
- Widths: imm[15:0] extended to 32 bits; jp_address truncated to AW bits.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_J
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_JR
  - ALU_ADD..ALU_SLT encodings
  - the ID/EX control bundle typedef
- One sub-module, register_file: 32x32, async active-low clear, two read ports, one write port, with bypass.

Test Plan:
- Reset with reset = 0 mid-stream -> all ex_* = 0 immediately, without waiting for a clock; after release, r5 reads 0.
- wb_en = 1, wb_addr = 3, wb_data = 0x0000_00AA, while instruction add $4,$3,$3 (0x00632020) in the same cycle -> next edge: ex_rs_data = ex_rt_data = 0xAA, ex_dest = 4, ex_alu_op = 0, ex_reg_write = 1.
- addi $2,$0,-1 (0x2002FFFF) -> ex_imm = 0xFFFFFFFF, ex_alu_src = 1. ori $2,$0,0xFFFF (0x3402FFFF) -> ex_imm = 0x0000FFFF.
- lw $5,0($1) followed by add $6,$5,$0 -> stall = 1 for exactly one cycle, one bubble (ex_valid = 0), then the add issues with ex_rs_data = loaded value via bypass.
- j 0x14 (0x08000014) -> same cycle: mux_ctrl = 1, jp_address = 0x14. Next-cycle word is killed (ex_valid = 0).
- With r7 = 0x0C, jr $7 (0x00E00008) -> jp_address = 0x0C. Opcode 0x3F -> illegal = 1 and no write/mem control asserted.
